dcache_arbiter: RTL and testbench

- Shares the single-ported dcache memory array between two requesters: the memory-instruction port (regfile loads/stores) and the DMA port.
- Memory instructions win by default. A starvation counter guarantees DMA forward progress.
- Issues one access per cycle to the memory, tracks in-flight reads, and returns each read response to the requester that issued it.

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_resp_tracker.sv | 48 ++++
 rtl/dcache_arbiter.sv | 121 ++++++++++++
 tb/tb_dcache_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths and enums for the dcache arbiter slice
package dcache_pkg;
    localparam int DCACHE_ADDR_W = 15;
    localparam int DCACHE_DATA_W = 288;

    typedef enum logic {
        SRC_MI  = 1'b0,
        SRC_DMA = 1'b1
    } src_t;

    typedef enum logic {
        PRIO_MI  = 1'b0,
        PRIO_DMA = 1'b1
    } prio_t;
endpackage

// File: rtl/dcache_resp_tracker.sv
// rtl/dcache_resp_tracker.sv - read tag pipeline and response demux
module dcache_resp_tracker
    import dcache_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int DATA_W  = DCACHE_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_valid,
    input  logic              push_src,
    input  logic [DATA_W-1:0] mem_dat_r,
    output logic              mi_rvalid,
    output logic [DATA_W-1:0] mi_dat_r,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_dat_r
);
    // Stage 0 lines up with the registered mem_re; the last stage lines up with mem_dat_r.
    logic [MEM_LAT:0] tag_v;
    logic [MEM_LAT:0] tag_src;
    logic             hit_mi;
    logic             hit_dma;

    assign hit_mi  = tag_v[MEM_LAT] && (src_t'(tag_src[MEM_LAT]) == SRC_MI);
    assign hit_dma = tag_v[MEM_LAT] && (src_t'(tag_src[MEM_LAT]) == SRC_DMA);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_v      <= '0;
            tag_src    <= '0;
            mi_rvalid  <= 1'b0;
            dma_rvalid <= 1'b0;
            mi_dat_r   <= '0;
            dma_dat_r  <= '0;
        end else begin
            tag_v      <= {tag_v[MEM_LAT-1:0], push_valid};
            tag_src    <= {tag_src[MEM_LAT-1:0], push_src};
            mi_rvalid  <= hit_mi;
            dma_rvalid <= hit_dma;
            if (hit_mi) begin
                mi_dat_r <= mem_dat_r;
            end
            if (hit_dma) begin
                dma_dat_r <= mem_dat_r;
            end
        end
    end
endmodule

// File: rtl/dcache_arbiter.sv
// rtl/dcache_arbiter.sv - MI/DMA arbiter for the single-ported dcache array
module dcache_arbiter
    import dcache_pkg::*;
#(
    parameter int ADDR_W       = DCACHE_ADDR_W,
    parameter int DATA_W       = DCACHE_DATA_W,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mi_valid,
    output logic              mi_ready,
    input  logic              mi_we,
    input  logic [ADDR_W-1:0] mi_addr,
    input  logic [DATA_W-1:0] mi_dat_w,
    output logic              mi_rvalid,
    output logic [DATA_W-1:0] mi_dat_r,
    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_dat_w,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_dat_r,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dat_w,
    input  logic [DATA_W-1:0] mem_dat_r
);
    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    prio_t            prio;
    prio_t            prio_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             mi_fire;
    logic             dma_fire;

    always_comb begin
        mi_ready  = 1'b0;
        dma_ready = 1'b0;
        if (reset_n) begin
            if (prio == PRIO_MI) begin
                mi_ready  = mi_valid;
                dma_ready = dma_valid && !mi_valid;
            end else begin
                dma_ready = dma_valid;
                mi_ready  = mi_valid && !dma_valid;
            end
        end
    end

    assign mi_fire  = mi_valid && mi_ready;
    assign dma_fire = dma_valid && dma_ready;

    always_comb begin
        wait_cnt_next = wait_cnt;
        prio_next     = prio;
        if (dma_fire || !dma_valid) begin
            wait_cnt_next = '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt_next = wait_cnt + 1'b1;
        end
        if (dma_fire) begin
            prio_next = PRIO_MI;
        end else if (prio == PRIO_MI && wait_cnt_next == LIMIT) begin
            prio_next = PRIO_DMA;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio     <= PRIO_MI;
            wait_cnt <= '0;
        end else begin
            prio     <= prio_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_dat_w <= '0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (mi_fire) begin
                mem_re    <= !mi_we;
                mem_we    <= mi_we;
                mem_addr  <= mi_addr;
                mem_dat_w <= mi_dat_w;
            end else if (dma_fire) begin
                mem_re    <= !dma_we;
                mem_we    <= dma_we;
                mem_addr  <= dma_addr;
                mem_dat_w <= dma_dat_w;
            end
        end
    end

    dcache_resp_tracker #(
        .MEM_LAT (MEM_LAT),
        .DATA_W  (DATA_W)
    ) u_resp_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid ((mi_fire && !mi_we) || (dma_fire && !dma_we)),
        .push_src   (dma_fire),
        .mem_dat_r  (mem_dat_r),
        .mi_rvalid  (mi_rvalid),
        .mi_dat_r   (mi_dat_r),
        .dma_rvalid (dma_rvalid),
        .dma_dat_r  (dma_dat_r)
    );
endmodule

// File: tb/tb_dcache_arbiter.sv
// tb/tb_dcache_arbiter.sv - randomized self-checking bench for dcache_arbiter
module tb_dcache_arbiter;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 288;
    localparam int MEM_LAT = 1;
    localparam int LIMIT   = 4;
    localparam int NCYC    = 2000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              mi_valid = 1'b0, mi_we = 1'b0;
    logic [ADDR_W-1:0] mi_addr = '0;
    logic [DATA_W-1:0] mi_dat_w = '0;
    logic              dma_valid = 1'b0, dma_we = 1'b0;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic [DATA_W-1:0] dma_dat_w = '0;
    logic              mi_ready, dma_ready, mi_rvalid, dma_rvalid;
    logic [DATA_W-1:0] mi_dat_r, dma_dat_r;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dat_w;
    logic [DATA_W-1:0] mem_dat_r;

    always #5 clk = ~clk;

    dcache_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .mi_valid(mi_valid), .mi_ready(mi_ready), .mi_we(mi_we), .mi_addr(mi_addr),
        .mi_dat_w(mi_dat_w), .mi_rvalid(mi_rvalid), .mi_dat_r(mi_dat_r),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_dat_w(dma_dat_w), .dma_rvalid(dma_rvalid), .dma_dat_r(dma_dat_r),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r)
    );

    function automatic logic [DATA_W-1:0] init_val(input int a);
        return {9{(32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000}};
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Single-port memory with one cycle read latency, 16 lines aliased by addr[3:0].
    logic [DATA_W-1:0] mem_arr [16];
    bit                mem_wr  [16];
    always @(posedge clk) begin
        if (mem_we) begin
            mem_arr[mem_addr[3:0]] <= mem_dat_w;
            mem_wr[mem_addr[3:0]]  <= 1'b1;
        end
        if (mem_re) begin
            mem_dat_r <= mem_wr[mem_addr[3:0]] ? mem_arr[mem_addr[3:0]] : init_val(int'(mem_addr[3:0]));
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int                due;
        bit                src;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t             rq[$];
    logic [DATA_W-1:0] shadow [16];
    bit                sh_wr  [16];
    bit                prio_dma;
    int                waits;
    logic              e_re, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_datw, e_mi_dat, e_dma_dat;

    initial begin
        bit                rst, mi_hold, dma_hold, e_mi_rv, e_dma_rv, e_mi_rdy, e_dma_rdy;
        bit                w_we, w_src;
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_dat, rd;
        resp_t             r;
        mi_hold = 0; dma_hold = 0; prio_dma = 0; waits = 0;
        e_re = 0; e_we = 0; e_addr = '0; e_datw = '0; e_mi_dat = '0; e_dma_dat = '0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            rst = (cyc < 2) || ($urandom_range(0, 59) == 0);
            reset_n = !rst;
            if (!mi_hold) begin
                mi_valid = ($urandom_range(0, 9) < 7);
                mi_we    = $urandom_range(0, 2) == 0;
                mi_addr  = ADDR_W'($urandom);
                mi_dat_w = rand_data();
            end
            if (!dma_hold) begin
                dma_valid = ($urandom_range(0, 9) < 6);
                dma_we    = $urandom_range(0, 2) == 0;
                dma_addr  = ADDR_W'($urandom);
                dma_dat_w = rand_data();
            end
            #1;
            e_mi_rdy  = !rst && mi_valid && (!dma_valid || !prio_dma);
            e_dma_rdy = !rst && dma_valid && (!mi_valid || prio_dma);
            check("mi_ready", DATA_W'(mi_ready), DATA_W'(e_mi_rdy));
            check("dma_ready", DATA_W'(dma_ready), DATA_W'(e_dma_rdy));
            if (cyc > 0) begin
                e_mi_rv = 0; e_dma_rv = 0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    r = rq.pop_front();
                    if (r.src) begin e_dma_rv = 1; e_dma_dat = r.data; end
                    else begin e_mi_rv = 1; e_mi_dat = r.data; end
                end
                check("mem_re", DATA_W'(mem_re), DATA_W'(e_re));
                check("mem_we", DATA_W'(mem_we), DATA_W'(e_we));
                check("mem_addr", DATA_W'(mem_addr), DATA_W'(e_addr));
                check("mem_dat_w", mem_dat_w, e_datw);
                check("mi_rvalid", DATA_W'(mi_rvalid), DATA_W'(e_mi_rv));
                check("dma_rvalid", DATA_W'(dma_rvalid), DATA_W'(e_dma_rv));
                check("mi_dat_r", mi_dat_r, e_mi_dat);
                check("dma_dat_r", dma_dat_r, e_dma_dat);
            end
            if (rst) begin
                rq.delete();
                prio_dma = 0; waits = 0;
                e_re = 0; e_we = 0; e_addr = '0; e_datw = '0; e_mi_dat = '0; e_dma_dat = '0;
                mi_hold = 0; dma_hold = 0;
            end else begin
                e_re = 0; e_we = 0;
                if (e_mi_rdy || e_dma_rdy) begin
                    w_we   = e_mi_rdy ? mi_we : dma_we;
                    w_addr = e_mi_rdy ? mi_addr : dma_addr;
                    w_dat  = e_mi_rdy ? mi_dat_w : dma_dat_w;
                    w_src  = e_dma_rdy;
                    e_re = !w_we; e_we = w_we; e_addr = w_addr; e_datw = w_dat;
                    if (w_we) begin
                        shadow[w_addr[3:0]] = w_dat;
                        sh_wr[w_addr[3:0]]  = 1;
                    end else begin
                        rd = sh_wr[w_addr[3:0]] ? shadow[w_addr[3:0]] : init_val(int'(w_addr[3:0]));
                        rq.push_back('{cyc + 2 + MEM_LAT, w_src, rd});
                    end
                end
                if (e_dma_rdy) begin
                    waits = 0; prio_dma = 0;
                end else if (dma_valid) begin
                    if (waits < LIMIT) waits++;
                    if (waits == LIMIT) prio_dma = 1;
                end else begin
                    waits = 0;
                end
                mi_hold  = mi_valid && !e_mi_rdy;
                dma_hold = dma_valid && !e_dma_rdy;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
